hazard3_sba_initiator: RTL

System Bus Access (SBA) initiator for the Hazard3 Debug Module. It implements the RISC-V debug `sbcs`, `sbaddress0` and `sbdata0` registers behind the DMI register port, and issues single transfers on the `dbg_sbus_*` valid/ready interface. That interface feeds the CPU's single-port AHB5 arbiter, where SBA sits below load/store and above instruction fetch. It runs on `clk_always_on`, so a debugger can access memory while the core clock is gated.

---
 rtl/hazard3_sba_initiator_if.sv | 43 ++++
 rtl/hazard3_sba_initiator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_sba_initiator_if.sv
// ---------------------------------------------------------------------------
// hazard3_sba_initiator_if: DMI register port and dbg_sbus transfer bundle.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hazard3_sba_initiator_if #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
);
   logic              dmi_sel;
   logic              dmi_write;
   logic [6:0]        dmi_addr;
   logic [31:0]       dmi_wdata;
   logic [31:0]       dmi_rdata;

   logic [W_ADDR-1:0] sbus_addr;
   logic              sbus_write;
   logic [1:0]        sbus_size;
   logic              sbus_vld;
   logic              sbus_rdy;
   logic              sbus_err;
   logic [W_DATA-1:0] sbus_wdata;
   logic [W_DATA-1:0] sbus_rdata;

   // The SBA initiator: serves DMI, drives the system bus request.
   modport slave (
      input  dmi_sel, dmi_write, dmi_addr, dmi_wdata,
      output dmi_rdata,
      output sbus_addr, sbus_write, sbus_size, sbus_vld, sbus_wdata,
      input  sbus_rdy, sbus_err, sbus_rdata
   );

   // The environment: debug transport plus bus arbiter.
   modport master (
      output dmi_sel, dmi_write, dmi_addr, dmi_wdata,
      input  dmi_rdata,
      input  sbus_addr, sbus_write, sbus_size, sbus_vld, sbus_wdata,
      output sbus_rdy, sbus_err, sbus_rdata
   );
endinterface

`default_nettype wire

// File: rtl/hazard3_sba_initiator.sv
// ---------------------------------------------------------------------------
// hazard3_sba_initiator: RISC-V debug System Bus Access (sbcs/sbaddress0/sbdata0).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard3_sba_initiator #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
) (
   input  wire                          clk_always_on,
   input  wire                          rst_n,
   hazard3_sba_initiator_if.slave       sba
);

   localparam logic [6:0] C_ADDR_SBCS  = 7'h38;
   localparam logic [6:0] C_ADDR_SBADR = 7'h39;
   localparam logic [6:0] C_ADDR_SBDAT = 7'h3c;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [W_ADDR-1:0]   sbaddress_q, sbaddress_d;
   logic [W_DATA-1:0]   sbdata_q, sbdata_d;
   logic                sbbusyerror_q, sbbusyerror_d;
   logic                sbreadonaddr_q, sbreadonaddr_d;
   logic [2:0]          sbaccess_q, sbaccess_d;
   logic                sbautoinc_q, sbautoinc_d;
   logic                sbreadondata_q, sbreadondata_d;
   logic [2:0]          sberror_q, sberror_d;

   logic [W_ADDR-1:0]   bus_addr_q, bus_addr_d;
   logic                bus_write_q, bus_write_d;
   logic [1:0]          bus_size_q, bus_size_d;
   logic                bus_vld_q, bus_vld_d;
   logic [W_DATA-1:0]   bus_wdata_q, bus_wdata_d;

   logic                w_sbcs_wr;
   logic                w_addr_wr;
   logic                w_data_wr;
   logic                w_data_rd;
   logic                w_blocked;
   logic [W_ADDR-1:0]   w_wdata_addr;
   logic [31:0]         w_addr_rd;
   logic [31:0]         w_sbcs;
   logic [31:0]         w_rd_shifted;
   logic [31:0]         w_rd_aligned;
   logic                w_req;
   logic                w_req_write;
   logic [W_ADDR-1:0]   w_req_addr;
   logic                w_misaligned;
   logic                w_unused;

   assign w_sbcs_wr = sba.dmi_sel &&  sba.dmi_write && (sba.dmi_addr == C_ADDR_SBCS);
   assign w_addr_wr = sba.dmi_sel &&  sba.dmi_write && (sba.dmi_addr == C_ADDR_SBADR);
   assign w_data_wr = sba.dmi_sel &&  sba.dmi_write && (sba.dmi_addr == C_ADDR_SBDAT);
   assign w_data_rd = sba.dmi_sel && !sba.dmi_write && (sba.dmi_addr == C_ADDR_SBDAT);
   assign w_blocked = (sberror_q != 3'd0) || sbbusyerror_q;

   // sbaddress0 is a 32-bit DMI register regardless of the bus address width.
   generate
      if (W_ADDR > 32) begin : g_addr_wide
         assign w_wdata_addr = {{(W_ADDR-32){1'b0}}, sba.dmi_wdata};
         assign w_addr_rd    = sbaddress_q[31:0];
      end else if (W_ADDR == 32) begin : g_addr_full
         assign w_wdata_addr = sba.dmi_wdata;
         assign w_addr_rd    = sbaddress_q;
      end else begin : g_addr_narrow
         assign w_wdata_addr = sba.dmi_wdata[W_ADDR-1:0];
         assign w_addr_rd    = {{(32-W_ADDR){1'b0}}, sbaddress_q};
      end
   endgenerate

   assign w_sbcs = {3'd1, 6'd0, sbbusyerror_q, (state_q == S_BUSY), sbreadonaddr_q,
                    sbaccess_q, sbautoinc_q, sbreadondata_q, sberror_q,
                    7'(W_ADDR), 2'b00, 3'b111};

   always_comb begin
      sba.dmi_rdata = 32'd0;
      case (sba.dmi_addr)
         C_ADDR_SBCS:  sba.dmi_rdata = w_sbcs;
         C_ADDR_SBADR: sba.dmi_rdata = w_addr_rd;
         C_ADDR_SBDAT: sba.dmi_rdata = sbdata_q;
         default:      sba.dmi_rdata = 32'd0;
      endcase
   end

   function automatic logic [31:0] f_lanes(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'd0:    return {4{d[7:0]}};
         2'd1:    return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   // Narrow reads land on their byte lanes; move them down to bit 0.
   assign w_rd_shifted = sba.sbus_rdata >> {bus_addr_q[1:0], 3'b000};

   always_comb begin
      case (bus_size_q)
         2'd0:    w_rd_aligned = {24'd0, w_rd_shifted[7:0]};
         2'd1:    w_rd_aligned = {16'd0, w_rd_shifted[15:0]};
         default: w_rd_aligned = w_rd_shifted;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      sbaddress_d    = sbaddress_q;
      sbdata_d       = sbdata_q;
      sbbusyerror_d  = sbbusyerror_q;
      sbreadonaddr_d = sbreadonaddr_q;
      sbaccess_d     = sbaccess_q;
      sbautoinc_d    = sbautoinc_q;
      sbreadondata_d = sbreadondata_q;
      sberror_d      = sberror_q;
      bus_addr_d     = bus_addr_q;
      bus_write_d    = bus_write_q;
      bus_size_d     = bus_size_q;
      bus_vld_d      = bus_vld_q;
      bus_wdata_d    = bus_wdata_q;
      w_req          = 1'b0;
      w_req_write    = 1'b0;
      w_req_addr     = sbaddress_q;
      w_misaligned   = 1'b0;

      if (w_sbcs_wr) begin
         sbreadonaddr_d = sba.dmi_wdata[20];
         sbaccess_d     = sba.dmi_wdata[19:17];
         sbautoinc_d    = sba.dmi_wdata[16];
         sbreadondata_d = sba.dmi_wdata[15];
         sberror_d      = sberror_q & ~sba.dmi_wdata[14:12];
         if (sba.dmi_wdata[22]) begin
            sbbusyerror_d = 1'b0;
         end
      end

      if (state_q == S_BUSY) begin
         if (w_addr_wr || w_data_wr || w_data_rd) begin
            sbbusyerror_d = 1'b1;
         end
         if (sba.sbus_rdy) begin
            state_d   = S_IDLE;
            bus_vld_d = 1'b0;
            // Applied after the W1C above so a fresh bus error is never lost.
            if (sba.sbus_err) begin
               sberror_d = 3'd2;
            end else begin
               if (!bus_write_q) begin
                  sbdata_d = w_rd_aligned;
               end
               if (sbautoinc_q) begin
                  sbaddress_d = sbaddress_q + (W_ADDR'(1) << bus_size_q);
               end
            end
         end
      end else begin
         if (w_addr_wr) begin
            sbaddress_d = w_wdata_addr;
            w_req       = sbreadonaddr_q && !w_blocked;
            w_req_addr  = w_wdata_addr;
         end
         if (w_data_wr) begin
            sbdata_d    = sba.dmi_wdata;
            w_req       = !w_blocked;
            w_req_write = 1'b1;
         end
         if (w_data_rd) begin
            w_req = sbreadondata_q && !w_blocked;
         end

         case (sbaccess_q)
            3'd1:    w_misaligned = w_req_addr[0];
            3'd2:    w_misaligned = |w_req_addr[1:0];
            default: w_misaligned = 1'b0;
         endcase

         if (w_req) begin
            if (sbaccess_q > 3'd2) begin
               sberror_d = 3'd4;
            end else if (w_misaligned) begin
               sberror_d = 3'd3;
            end else begin
               state_d     = S_BUSY;
               bus_vld_d   = 1'b1;
               bus_addr_d  = w_req_addr;
               bus_write_d = w_req_write;
               bus_size_d  = sbaccess_q[1:0];
               bus_wdata_d = f_lanes(sbaccess_q[1:0],
                                     w_req_write ? sba.dmi_wdata : sbdata_q);
            end
         end
      end
   end

   always_ff @(posedge clk_always_on or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         sbaddress_q    <= '0;
         sbdata_q       <= '0;
         sbbusyerror_q  <= 1'b0;
         sbreadonaddr_q <= 1'b0;
         sbaccess_q     <= 3'd2;
         sbautoinc_q    <= 1'b0;
         sbreadondata_q <= 1'b0;
         sberror_q      <= 3'd0;
         bus_addr_q     <= '0;
         bus_write_q    <= 1'b0;
         bus_size_q     <= 2'd0;
         bus_vld_q      <= 1'b0;
         bus_wdata_q    <= '0;
      end else begin
         state_q        <= state_d;
         sbaddress_q    <= sbaddress_d;
         sbdata_q       <= sbdata_d;
         sbbusyerror_q  <= sbbusyerror_d;
         sbreadonaddr_q <= sbreadonaddr_d;
         sbaccess_q     <= sbaccess_d;
         sbautoinc_q    <= sbautoinc_d;
         sbreadondata_q <= sbreadondata_d;
         sberror_q      <= sberror_d;
         bus_addr_q     <= bus_addr_d;
         bus_write_q    <= bus_write_d;
         bus_size_q     <= bus_size_d;
         bus_vld_q      <= bus_vld_d;
         bus_wdata_q    <= bus_wdata_d;
      end
   end

   assign sba.sbus_addr  = bus_addr_q;
   assign sba.sbus_write = bus_write_q;
   assign sba.sbus_size  = bus_size_q;
   assign sba.sbus_vld   = bus_vld_q;
   assign sba.sbus_wdata = bus_wdata_q;

   assign w_unused = ^{sba.dmi_wdata, sbaddress_q};

endmodule

`default_nettype wire
